// File: rtl/my_ep_tx_cpl_engine_if.sv
// Request, memory-read and TRN transmit signals between the memory controller, the completion engine and the core.
// Purely structural, no latency of its own.
// Backpressure travels on trn_tdst_rdy_n from core to engine; the engine stalls its read port accordingly.
interface my_ep_tx_cpl_engine_if;
    logic [15:0] cfg_completer_id;
    logic        req_compl_i;
    logic        req_compl_with_data_i;
    logic [2:0]  req_tc_i;
    logic        req_td_i;
    logic        req_ep_i;
    logic [1:0]  req_attr_i;
    logic [9:0]  req_len_i;
    logic [15:0] req_rid_i;
    logic [7:0]  req_tag_i;
    logic [7:0]  req_be_i;
    logic [12:0] req_addr_i;
    logic        compl_done_o;
    logic [10:0] rd_addr_o;
    logic [3:0]  rd_be_o;
    logic [31:0] rd_data_i;
    logic [31:0] trn_td;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n;
    logic [5:0]  trn_tbuf_av;

    // Engine side
    modport master (
        input  cfg_completer_id, req_compl_i, req_compl_with_data_i, req_tc_i, req_td_i,
               req_ep_i, req_attr_i, req_len_i, req_rid_i, req_tag_i, req_be_i, req_addr_i,
               rd_data_i, trn_tdst_rdy_n, trn_tbuf_av,
        output compl_done_o, rd_addr_o, rd_be_o, trn_td, trn_tsof_n, trn_teof_n,
               trn_tsrc_rdy_n, trn_tsrc_dsc_n
    );

    // Memory controller / TRN core side
    modport slave (
        output cfg_completer_id, req_compl_i, req_compl_with_data_i, req_tc_i, req_td_i,
               req_ep_i, req_attr_i, req_len_i, req_rid_i, req_tag_i, req_be_i, req_addr_i,
               rd_data_i, trn_tdst_rdy_n, trn_tbuf_av,
        input  compl_done_o, rd_addr_o, rd_be_o, trn_td, trn_tsof_n, trn_teof_n,
               trn_tsrc_rdy_n, trn_tsrc_dsc_n
    );
endinterface

// File: rtl/my_ep_tx_cpl_engine.sv
// Builds a 3DW Cpl/CplD (or UR Cpl for oversize reads) on the 32-bit TRN TX port; optional MY_TXE_BUF_AV_CHECK_EN gates start on trn_tbuf_av.
// Latency: HDR0 one clk after req_compl_i; one FETCH bubble between consecutive data DWs; done pulse one clk after the last beat.
// Backpressure: each beat (td/sof/eof) holds until trn_tdst_rdy_n is low; rd_addr_o only advances on an accepted data beat.
module my_ep_tx_cpl_engine #(
    parameter int MAX_LEN_DW = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    my_ep_tx_cpl_engine_if.master    bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] HDR0     = 3'd1;
    localparam logic [2:0] HDR1     = 3'd2;
    localparam logic [2:0] HDR2     = 3'd3;
    localparam logic [2:0] DATA     = 3'd4;
    localparam logic [2:0] FETCH    = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;
    localparam logic [2:0] WAIT_BUF = 3'd7;

    localparam logic [11:0] MAX_LEN = 12'(MAX_LEN_DW);

    logic [2:0]  state;
    logic [2:0]  tc_q;
    logic        td_q;
    logic        ep_q;
    logic [1:0]  attr_q;
    logic [9:0]  len_q;
    logic [15:0] rid_q;
    logic [7:0]  tag_q;
    logic [7:0]  be_q;
    logic [4:0]  addr_q;
    logic        with_data_q;
    logic        ur_q;
    logic [10:0] cnt_q;
    logic [10:0] rd_addr_q;
    logic [3:0]  rd_be_q;

    logic [10:0] req_eff_len;
    logic        req_ur;
    logic [10:0] eff_len;
    logic [1:0]  tz;
    logic [1:0]  lz;
    logic [1:0]  lo_bits;
    logic [11:0] bc1;
    logic [12:0] bc_full;
    logic [11:0] byte_count;
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    logic [31:0] td;
    logic        sof_n;
    logic        eof_n;
    logic        src_n;
    logic        accept;

    // A length field of 0 means 1024 DW; reads longer than MAX_LEN_DW are answered with UR.
    assign req_eff_len = (bus.req_len_i == 10'd0) ? 11'd1024 : {1'b0, bus.req_len_i};
    assign req_ur      = bus.req_compl_with_data_i && ({1'b0, req_eff_len} > MAX_LEN);
    assign eff_len     = (len_q == 10'd0) ? 11'd1024 : {1'b0, len_q};

    // Byte count and lower address derived from the latched byte enables.
    always_comb begin
        tz = 2'd0;
        casez (be_q[3:0])
            4'b???1: tz = 2'd0;
            4'b??10: tz = 2'd1;
            4'b?100: tz = 2'd2;
            4'b1000: tz = 2'd3;
            default: tz = 2'd0;
        endcase
        lz = 2'd0;
        casez (be_q[7:4])
            4'b1???: lz = 2'd0;
            4'b01??: lz = 2'd1;
            4'b001?: lz = 2'd2;
            4'b0001: lz = 2'd3;
            default: lz = 2'd0;
        endcase
        bc1 = 12'd1;
        casez (be_q[3:0])
            4'b1??1:                    bc1 = 12'd4;
            4'b01?1, 4'b1?10:           bc1 = 12'd3;
            4'b0011, 4'b0110, 4'b1100:  bc1 = 12'd2;
            default:                    bc1 = 12'd1;
        endcase
        // The 13-bit difference truncates so that 1024 DW encodes as 0.
        bc_full = {eff_len, 2'b00} - 13'(tz) - 13'(lz);
        if (ur_q) begin
            byte_count = 12'd4;
        end else if (eff_len == 11'd1) begin
            byte_count = bc1;
        end else begin
            byte_count = bc_full[11:0];
        end
        lo_bits = tz;
    end

    assign dw0 = {1'b0, (with_data_q ? 2'b10 : 2'b00), 5'b01010, 1'b0, tc_q, 4'b0000,
                  td_q, ep_q, attr_q, 2'b00, (with_data_q ? len_q : 10'd0)};
    assign dw1 = {bus.cfg_completer_id, (ur_q ? 3'b001 : 3'b000), 1'b0, byte_count};
    assign dw2 = {rid_q, tag_q, 1'b0, addr_q, lo_bits};

    // TRN beat contents are a pure function of the state, so they stay put while stalled.
    always_comb begin
        td    = 32'd0;
        sof_n = 1'b1;
        eof_n = 1'b1;
        src_n = 1'b1;
        case (state)
            HDR0: begin
                td    = dw0;
                sof_n = 1'b0;
                src_n = 1'b0;
            end
            HDR1: begin
                td    = dw1;
                src_n = 1'b0;
            end
            HDR2: begin
                td    = dw2;
                eof_n = with_data_q;
                src_n = 1'b0;
            end
            DATA: begin
                td    = bus.rd_data_i;
                eof_n = (cnt_q != 11'd1);
                src_n = 1'b0;
            end
            default: begin
                td    = 32'd0;
            end
        endcase
    end

    assign accept             = !src_n && !bus.trn_tdst_rdy_n;
    assign bus.trn_td         = td;
    assign bus.trn_tsof_n     = sof_n;
    assign bus.trn_teof_n     = eof_n;
    assign bus.trn_tsrc_rdy_n = src_n;
    assign bus.trn_tsrc_dsc_n = 1'b1;
    assign bus.compl_done_o   = (state == DONE);
    assign bus.rd_addr_o      = rd_addr_q;
    assign bus.rd_be_o        = rd_be_q;

`ifndef MY_TXE_BUF_AV_CHECK_EN
    logic unused_buf_av;
    assign unused_buf_av = ^bus.trn_tbuf_av;
`endif
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.req_addr_i[1:0];

    // Packet sequencer: latch request, walk header DWs, then stream data with a fetch bubble per DW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tc_q        <= 3'd0;
            td_q        <= 1'b0;
            ep_q        <= 1'b0;
            attr_q      <= 2'd0;
            len_q       <= 10'd0;
            rid_q       <= 16'd0;
            tag_q       <= 8'd0;
            be_q        <= 8'd0;
            addr_q      <= 5'd0;
            with_data_q <= 1'b0;
            ur_q        <= 1'b0;
            cnt_q       <= 11'd0;
            rd_addr_q   <= 11'd0;
            rd_be_q     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_compl_i) begin
                        tc_q        <= bus.req_tc_i;
                        td_q        <= bus.req_td_i;
                        ep_q        <= bus.req_ep_i;
                        attr_q      <= bus.req_attr_i;
                        len_q       <= bus.req_len_i;
                        rid_q       <= bus.req_rid_i;
                        tag_q       <= bus.req_tag_i;
                        be_q        <= bus.req_be_i;
                        addr_q      <= bus.req_addr_i[6:2];
                        with_data_q <= bus.req_compl_with_data_i && !req_ur;
                        ur_q        <= req_ur;
                        cnt_q       <= req_eff_len;
                        rd_addr_q   <= bus.req_addr_i[12:2];
                        rd_be_q     <= bus.req_be_i[3:0];
`ifdef MY_TXE_BUF_AV_CHECK_EN
                        state       <= (bus.trn_tbuf_av != 6'd0) ? HDR0 : WAIT_BUF;
`else
                        state       <= HDR0;
`endif
                    end
                end
                WAIT_BUF: begin
                    if (bus.trn_tbuf_av != 6'd0) begin
                        state <= HDR0;
                    end
                end
                HDR0: if (accept) state <= HDR1;
                HDR1: if (accept) state <= HDR2;
                HDR2: if (accept) state <= with_data_q ? DATA : DONE;
                DATA: begin
                    if (accept) begin
                        if (cnt_q == 11'd1) begin
                            state <= DONE;
                        end else begin
                            cnt_q     <= cnt_q - 11'd1;
                            rd_addr_q <= rd_addr_q + 11'd1;
                            rd_be_q   <= (cnt_q == 11'd2) ? be_q[7:4] : 4'hF;
                            state     <= FETCH;
                        end
                    end
                end
                FETCH:   state <= DATA;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
